// File: rtl/exa_crosb_input_arbiter_vcs_if.sv
// Input-arbiter bundle of the crossbar: VC heads, credits and grants in,
// the chosen request and clear-to-send out.
interface exa_crosb_input_arbiter_vcs_if #(
    parameter int unsigned prio_num   = 2,
    parameter int unsigned vc_num     = 3,
    parameter int unsigned output_num = 8
);
    localparam int unsigned N   = prio_num * vc_num;
    localparam int unsigned VCW = $clog2(N);
    localparam int unsigned OW  = $clog2(output_num);

    logic [N-1:0]                       i_has_packet;
    logic [N-1:0][output_num-1:0]       i_dest;
    logic [N-1:0][VCW-1:0]              i_output_vc;
    logic [output_num-1:0][N-1:0]       output_fifo_credits;
    logic [output_num-1:0][N-1:0]       i_grant_from_output_arbiter;
    logic                               i_last;
    logic [prio_num-1:0][vc_num-1:0]    o_request_array;
    logic [output_num-1:0][N-1:0]       o_selected_request;
    logic [VCW-1:0]                     o_selected_vc;
    logic [OW-1:0]                      o_dest_output;
    logic [VCW-1:0]                     o_dest_vc;
    logic                               o_cts;
    logic [N-1:0][output_num-1:0]       o_dest;
    logic [N-1:0][VCW-1:0]              o_output_vc;

    modport master (
        output i_has_packet, i_dest, i_output_vc, output_fifo_credits,
               i_grant_from_output_arbiter, i_last,
        input  o_request_array, o_selected_request, o_selected_vc,
               o_dest_output, o_dest_vc, o_cts, o_dest, o_output_vc
    );

    modport slave (
        input  i_has_packet, i_dest, i_output_vc, output_fifo_credits,
               i_grant_from_output_arbiter, i_last,
        output o_request_array, o_selected_request, o_selected_vc,
               o_dest_output, o_dest_vc, o_cts, o_dest, o_output_vc
    );
endinterface

// File: rtl/exa_crosb_input_arbiter_vcs.sv
// Per-input crossbar arbiter: strict priority between classes, round-robin
// inside a class, request held until granted and then clear-to-send to i_last.
module exa_crosb_input_arbiter_vcs #(
    parameter int unsigned prio_num   = 2,
    parameter int unsigned vc_num     = 3,
    parameter int unsigned output_num = 8
) (
    input logic                          clk,
    input logic                          resetn,
    exa_crosb_input_arbiter_vcs_if.slave bus
);
    localparam int unsigned N   = prio_num * vc_num;
    localparam int unsigned VCW = $clog2(N);
    localparam int unsigned OW  = $clog2(output_num);
    localparam int unsigned PW  = (prio_num > 1) ? $clog2(prio_num) : 1;
    localparam int unsigned RW  = (vc_num > 1) ? $clog2(vc_num) : 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;

    state_e                        state_q, state_d;
    logic [VCW-1:0]                sel_vc_q, sel_vc_d;
    logic [OW-1:0]                 dest_out_q, dest_out_d;
    logic [VCW-1:0]                dest_vc_q, dest_vc_d;
    logic [PW-1:0]                 prio_sel_q, prio_sel_d;
    logic [prio_num-1:0][RW-1:0]   ptr_q, ptr_d;

    logic [N-1:0]                  elig;
    logic [output_num-1:0]         col;
    logic [output_num-1:0]         dest_k;
    logic                          pick_found;
    logic                          class_hit;
    logic [PW-1:0]                 pick_p;
    logic [RW-1:0]                 pick_v;
    logic [VCW-1:0]                pick_k;
    logic [VCW-1:0]                cand_k;
    int unsigned                   idx;
    logic                          grant_hit;

    function automatic logic [OW-1:0] enc_dest(input logic [output_num-1:0] d);
        enc_dest = '0;
        for (int unsigned o = 0; o < output_num; o++)
            if (d[o]) enc_dest = OW'(o);
    endfunction

    // A VC is eligible only with a single-hot destination whose output VC has credit.
    always_comb begin
        elig   = '0;
        col    = '0;
        dest_k = '0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned o = 0; o < output_num; o++)
                col[o] = bus.output_fifo_credits[o][bus.i_output_vc[k]];
            dest_k  = bus.i_dest[k];
            elig[k] = bus.i_has_packet[k]
                   && (32'(bus.i_output_vc[k]) < N)
                   && (dest_k != '0)
                   && ((dest_k & (dest_k - output_num'(1))) == '0)
                   && (|(dest_k & col));
        end
    end

    // Later (higher) classes overwrite earlier ones, giving strict priority.
    always_comb begin
        pick_found = 1'b0;
        class_hit  = 1'b0;
        pick_p     = '0;
        pick_v     = '0;
        idx        = 0;
        cand_k     = '0;
        for (int unsigned p = 0; p < prio_num; p++) begin
            if (|elig[p*vc_num +: vc_num]) begin
                pick_found = 1'b1;
                pick_p     = PW'(p);
                class_hit  = 1'b0;
                for (int unsigned off = 1; off <= vc_num; off++) begin
                    idx    = (32'(ptr_q[p]) + off) % vc_num;
                    cand_k = VCW'(p * vc_num + idx);
                    if (!class_hit && elig[cand_k]) begin
                        class_hit = 1'b1;
                        pick_v    = RW'(idx);
                    end
                end
            end
        end
        pick_k = VCW'(32'(pick_p) * vc_num + 32'(pick_v));
    end

    assign grant_hit = bus.i_grant_from_output_arbiter[dest_out_q][dest_vc_q];

    always_comb begin
        state_d    = state_q;
        sel_vc_d   = sel_vc_q;
        dest_out_d = dest_out_q;
        dest_vc_d  = dest_vc_q;
        prio_sel_d = prio_sel_q;
        ptr_d      = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = REQ;
                    sel_vc_d   = pick_k;
                    dest_out_d = enc_dest(bus.i_dest[pick_k]);
                    dest_vc_d  = bus.i_output_vc[pick_k];
                    prio_sel_d = pick_p;
                end
            end
            REQ: begin
                // Pointer commit is deferred to REQ; no selection can happen before IDLE returns.
                ptr_d[prio_sel_q] = RW'(32'(sel_vc_q) - 32'(prio_sel_q) * vc_num);
                if (grant_hit)
                    state_d = XFER;
                else if (!elig[sel_vc_q])
                    state_d = IDLE;
            end
            XFER: begin
                if (bus.i_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            sel_vc_q   <= '0;
            dest_out_q <= '0;
            dest_vc_q  <= '0;
            prio_sel_q <= '0;
            for (int unsigned p = 0; p < prio_num; p++)
                ptr_q[p] <= RW'(vc_num - 1);
        end else begin
            state_q    <= state_d;
            sel_vc_q   <= sel_vc_d;
            dest_out_q <= dest_out_d;
            dest_vc_q  <= dest_vc_d;
            prio_sel_q <= prio_sel_d;
            ptr_q      <= ptr_d;
        end
    end

    always_comb begin
        bus.o_selected_request = '0;
        if (state_q != IDLE)
            bus.o_selected_request[dest_out_q][dest_vc_q] = 1'b1;
    end

    assign bus.o_cts           = ((state_q == REQ) && grant_hit) || (state_q == XFER);
    assign bus.o_selected_vc   = sel_vc_q;
    assign bus.o_dest_output   = dest_out_q;
    assign bus.o_dest_vc       = dest_vc_q;
    assign bus.o_request_array = elig;
    assign bus.o_dest          = bus.i_dest;
    assign bus.o_output_vc     = bus.i_output_vc;
endmodule

// File: tb/tb_exa_crosb_input_arbiter_vcs.sv
// Bench for the crossbar input arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level reference model.
module tb_exa_crosb_input_arbiter_vcs;
    localparam int PN  = 2;
    localparam int VN  = 3;
    localparam int ON  = 8;
    localparam int N   = PN * VN;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    exa_crosb_input_arbiter_vcs_if #(.prio_num(PN), .vc_num(VN), .output_num(ON)) bus();

    exa_crosb_input_arbiter_vcs #(.prio_num(PN), .vc_num(VN), .output_num(ON)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the packet currently owned (-1 = none), whether it was granted,
    // the last VC served per class, and the last announced selection.
    int busy_vc;
    bit m_granted;
    int m_svc, m_dout, m_dvc;
    int last_v[PN];

    function automatic bit m_elig(input int k);
        int ovc;
        ovc = int'(bus.i_output_vc[k]);
        if (!bus.i_has_packet[k] || $countones(bus.i_dest[k]) != 1 || ovc >= N) return 1'b0;
        return bus.output_fifo_credits[$clog2(bus.i_dest[k])][ovc];
    endfunction

    task automatic m_reset();
        busy_vc   = -1;
        m_granted = 1'b0;
        m_svc     = 0;
        m_dout    = 0;
        m_dvc     = 0;
        for (int p = 0; p < PN; p++) last_v[p] = VN - 1;
    endtask

    task automatic m_advance();
        int cls;
        int v;
        if (busy_vc < 0) begin
            cls = -1;
            for (int k = 0; k < N; k++) if (m_elig(k)) cls = k / VN;
            if (cls >= 0) begin
                for (int off = 1; off <= VN && busy_vc < 0; off++) begin
                    v = (last_v[cls] + off) % VN;
                    if (m_elig(cls * VN + v)) begin
                        busy_vc    = cls * VN + v;
                        m_svc      = busy_vc;
                        m_dout     = $clog2(bus.i_dest[busy_vc]);
                        m_dvc      = int'(bus.i_output_vc[busy_vc]);
                        last_v[cls] = v;
                        m_granted  = 1'b0;
                    end
                end
            end
        end else if (!m_granted) begin
            if (bus.i_grant_from_output_arbiter[m_dout][m_dvc]) m_granted = 1'b1;
            else if (!m_elig(busy_vc)) busy_vc = -1;
        end else if (bus.i_last) begin
            busy_vc   = -1;
            m_granted = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [N*ON-1:0] e_req;
        logic [N-1:0]    e_arr;
        logic            e_cts;
        for (int k = 0; k < N; k++) e_arr[k] = m_elig(k);
        e_req = '0;
        e_cts = 1'b0;
        if (busy_vc >= 0) begin
            e_req[m_dout * N + m_dvc] = 1'b1;
            e_cts = m_granted || bus.i_grant_from_output_arbiter[m_dout][m_dvc];
        end
        check("req_array", bus.o_request_array, e_arr);
        check("sel_req",   bus.o_selected_request, e_req);
        check("sel_vc",    bus.o_selected_vc, m_svc);
        check("dest_out",  bus.o_dest_output, m_dout);
        check("dest_vc",   bus.o_dest_vc, m_dvc);
        check("cts",       bus.o_cts, e_cts);
        check("dest_copy", bus.o_dest, bus.i_dest);
        check("ovc_copy",  bus.o_output_vc, bus.i_output_vc);
    endtask

    task automatic clear_inputs();
        bus.i_has_packet                = '0;
        bus.i_dest                      = '0;
        bus.i_output_vc                 = '0;
        bus.output_fifo_credits         = '0;
        bus.i_grant_from_output_arbiter = '0;
        bus.i_last                      = 1'b0;
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step();
        #1;
        compare_all();
        m_advance();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        clear_inputs();
        m_reset();
        #1;
        compare_all();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic async_reset_mid();
        #2 resetn = 1'b0;
        #1;
        check("rst_cts", bus.o_cts, 1'b0);
        check("rst_req", bus.o_selected_request, '0);
        m_reset();
        clear_inputs();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    int rr_exp[4] = '{0, 1, 2, 0};
    int r;

    initial begin
        clear_inputs();
        apply_reset();

        // First request: VC0 to output 1, output VC 0
        bus.i_has_packet[0] = 1'b1;
        bus.i_dest[0] = 8'h02;
        bus.i_output_vc[0] = 3'd0;
        bus.output_fifo_credits[1][0] = 1'b1;
        step();
        #1;
        check("t1_vc", bus.o_selected_vc, 0);
        check("t1_req", bus.o_selected_request[1][0], 1'b1);
        check("t1_dout", bus.o_dest_output, 1);
        bus.i_grant_from_output_arbiter[1][0] = 1'b1;
        bus.i_last = 1'b1;
        step();
        bus.i_grant_from_output_arbiter = '0;
        step();

        // Round-robin inside class 0
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            bus.i_has_packet[k] = 1'b1;
            bus.i_dest[k] = 8'h04;
            bus.i_output_vc[k] = 3'(k);
            bus.output_fifo_credits[2][k] = 1'b1;
        end
        bus.i_grant_from_output_arbiter = '1;
        bus.i_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_vc", bus.o_selected_vc, rr_exp[i]);
            step();
            step();
        end

        // Class 1 beats class 0
        apply_reset();
        bus.i_has_packet[1] = 1'b1; bus.i_dest[1] = 8'h01; bus.i_output_vc[1] = 3'd1;
        bus.i_has_packet[4] = 1'b1; bus.i_dest[4] = 8'h08; bus.i_output_vc[4] = 3'd4;
        bus.output_fifo_credits[0][1] = 1'b1;
        bus.output_fifo_credits[3][4] = 1'b1;
        step();
        check("prio_hi", bus.o_selected_vc, 4);
        bus.i_grant_from_output_arbiter = '1;
        bus.i_last = 1'b1;
        step();
        step();
        step();
        check("prio_hi2", bus.o_selected_vc, 4);
        step();
        step();
        bus.i_has_packet[4] = 1'b0;
        step();
        check("prio_lo", bus.o_selected_vc, 1);
        check("prio_lo_dout", bus.o_dest_output, 0);

        // 17-beat transfer
        apply_reset();
        bus.i_has_packet[0] = 1'b1;
        bus.i_dest[0] = 8'h02;
        bus.output_fifo_credits[1][0] = 1'b1;
        step();
        bus.i_grant_from_output_arbiter[1][0] = 1'b1;
        #1;
        check("t4_cts_same", bus.o_cts, 1'b1);
        step();
        bus.i_grant_from_output_arbiter = '0;
        repeat (15) step();
        bus.i_last = 1'b1;
        step();
        bus.i_last = 1'b0;
        #1;
        check("t4_cts_off", bus.o_cts, 1'b0);
        check("t4_req_off", bus.o_selected_request, '0);
        step();
        step();

        // Credit drop before grant, then a stray grant elsewhere
        apply_reset();
        bus.i_has_packet[0] = 1'b1; bus.i_dest[0] = 8'h01; bus.i_output_vc[0] = 3'd0;
        bus.i_has_packet[1] = 1'b1; bus.i_dest[1] = 8'h01; bus.i_output_vc[1] = 3'd1;
        bus.output_fifo_credits[0][0] = 1'b1;
        bus.output_fifo_credits[0][1] = 1'b1;
        bus.i_last = 1'b1;
        step();
        check("t5_sel0", bus.o_selected_vc, 0);
        bus.output_fifo_credits[0][0] = 1'b0;
        step();
        check("t5_wd", bus.o_selected_request, '0);
        step();
        check("t5_sel1", bus.o_selected_vc, 1);
        bus.i_grant_from_output_arbiter[3][2] = 1'b1;
        bus.i_grant_from_output_arbiter[0][0] = 1'b1;
        repeat (3) step();
        #1;
        check("t6_cts", bus.o_cts, 1'b0);
        check("t6_held", bus.o_selected_request[0][1], 1'b1);

        // Async reset in the middle of a transfer
        bus.i_last = 1'b0;
        bus.i_grant_from_output_arbiter[0][1] = 1'b1;
        step();
        bus.i_grant_from_output_arbiter = '0;
        step();
        async_reset_mid();

        // Random traffic
        for (int it = 0; it < 3000; it++) begin
            for (int k = 0; k < N; k++) begin
                bus.i_has_packet[k] = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 9);
                if (r == 0)      bus.i_dest[k] = '0;
                else if (r == 1) bus.i_dest[k] = 8'($urandom);
                else             bus.i_dest[k] = 8'(1 << $urandom_range(0, 7));
                bus.i_output_vc[k] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7))
                                                                 : 3'($urandom_range(0, 5));
            end
            bus.output_fifo_credits = 48'({$urandom, $urandom} | {$urandom, $urandom} | {$urandom, $urandom});
            bus.i_grant_from_output_arbiter = ($urandom_range(0, 5) == 0) ? 48'({$urandom, $urandom}) : '0;
            if (busy_vc >= 0 && $urandom_range(0, 2) == 0)
                bus.i_grant_from_output_arbiter[m_dout][m_dvc] = 1'b1;
            bus.i_last = ($urandom_range(0, 3) == 0);
            if (it == 1500) async_reset_mid();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/exa_crosb_input_arbiter_vcs.md
# exa_crosb_input_arbiter_vcs

Per-input arbiter of the crossbar (crosb) switch. It chooses one of the input port's prio_num×vc_num virtual-channel queues whose head packet has a free credit at its destination output VC. It raises a request toward the chosen output arbiter and, once granted, signals clear-to-send to the input buffer until the packet's last beat. Selection is strict priority between classes, with round-robin among the VCs inside a class.

## Interface
- prio_num, 2, priority classes; class 1 is high.
- vc_num, 3, VCs per class; flat VC index = prio*vc_num + vc. N = prio_num*vc_num.
- output_num, 8, crossbar outputs.
- clk  in  1  clock; one clock domain, every register on its rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- i_has_packet  in  N  bit k high: input VC k holds a packet head.
- i_dest  in  N × output_num  per input VC, one-hot destination output.
- i_output_vc  in  N × clog2(N)  per input VC, requested output VC.
- output_fifo_credits  in  output_num × N  1 = output o / VC j can accept a packet.
- i_grant_from_output_arbiter  in  output_num × N  grant from output arbiter o for output VC j.
- i_last  in  1  last beat of the packet in transfer.
- o_request_array  out  prio_num × vc_num  eligible requests, per class.
- o_selected_request  out  output_num × N  one-hot request to the output arbiters.
- o_selected_vc  out  clog2(N)  flat index of the chosen input VC.
- o_dest_output  out  clog2(output_num)  encoded destination of the selection.
- o_dest_vc  out  clog2(N)  output VC of the selection.
- o_cts  out  1  clear-to-send for o_selected_vc.
- o_dest  out  N × output_num  combinational copy of i_dest.
- o_output_vc  out  N × clog2(N)  combinational copy of i_output_vc.

## Operation
- Eligibility is combinational: request_array[p][v] = i_has_packet[k] & output_fifo_credits[onehot2bin(i_dest[k])][i_output_vc[k]], with k = p*vc_num + v.
  - i_dest[k] all-zero, or more than one bit set: VC k is not eligible.
- FSM states:
  - IDLE → REQ when any request is eligible. The selection is registered.
  - REQ → XFER when the matching grant bit is high.
  - REQ → IDLE when the selected VC loses eligibility before the grant (credit drop or has_packet low). The request is withdrawn and no transfer happens.
  - XFER → IDLE on i_last = 1.
- Selection rule:
  - If any class-1 request exists, pick among class 1 only, else among class 0.
  - Within a class, round-robin: first eligible VC at (ptr[p]+1), (ptr[p]+2), … mod vc_num.
  - ptr[p] updates to the chosen VC at each selection. Registered prio_sel_q = class of the selection.
- Outputs while in REQ or XFER:
  - o_selected_request[o_dest_output][o_dest_vc] = 1; all other bits 0.
  - o_selected_vc, o_dest_output and o_dest_vc are held constant.
- In IDLE, o_selected_request = 0. o_selected_vc etc. keep their last values.
- o_cts = (REQ & matching grant) | XFER. No other grant bit has any effect.
- Credits are sampled only for eligibility/withdrawal before the grant. A credit drop during XFER does not stop the transfer.

## Timing
- Reset values:
  - state IDLE; all outputs driven 0, except o_dest and o_output_vc, which follow their inputs.
  - ptr[p] = vc_num-1, so the first selection of each class after reset is the lowest eligible VC.
  - prio_sel_q = 0.
- Request latency: eligibility in cycle t → o_selected_request and o_selected_vc valid in cycle t+1.
- Grant: o_cts is high in the same cycle as the grant. It stays high through and including the i_last cycle.
- After i_last: state is IDLE at t+1. The next request can appear at t+2. No back-to-back overlap.
- Withdrawal: eligibility lost in cycle t → request is 0 in t+1.
  - If the grant and the withdrawal condition coincide in the same cycle, the grant wins and the FSM goes to XFER.
- i_last outside XFER is ignored. A class-1 arrival during REQ or XFER does not preempt; it is taken at the next IDLE.
- Async reset mid-packet: FSM returns to IDLE immediately; o_cts and requests drop.

## Test plan
- Reset, then has_packet[0] with dest 0x02, output VC 0, credit 1 → one cycle later o_selected_vc = 0, o_selected_request[1][0] = 1, o_dest_output = 1.
- Class 0 VCs 0, 1, 2 all eligible, grant + i_last repeatedly → o_selected_vc sequence 0, 1, 2, 0.
- VC 1 (class 0) and VC 4 (class 1) eligible → selects 4, prio_sel_q = 1. VC 1 is served only after class 1 has no eligible request.
- Grant in REQ → o_cts high the same cycle; i_last after 17 beats → o_cts low and request 0 the next cycle.
- Credit for the selected dest/VC drops before the grant → request withdrawn the next cycle; the other eligible VC is selected; o_cts never rises.
- Grant bit for a non-selected output/VC → no o_cts; state stays REQ.
